// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO using all 2**p_ADDR_WIDTH entries. It provides a registered fill level,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flagged #(
  parameter int p_DATA_WIDTH             = 8,
  parameter int p_ADDR_WIDTH             = 3,
  parameter int p_ALMOST_FULL_THRESHOLD  = 6,
  parameter int p_ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET_N,
  input  logic                    i_WRITE_REQUEST,
  input  logic                    i_READ_REQUEST,
  input  logic [p_DATA_WIDTH-1:0] i_INPUT,
  output logic [p_DATA_WIDTH-1:0] o_OUTPUT,
  output logic                    o_OUTPUT_VALID,
  output logic                    o_FIFO_EMPTY,
  output logic                    o_FIFO_FULL,
  output logic                    o_ALMOST_EMPTY,
  output logic                    o_ALMOST_FULL,
  output logic [p_ADDR_WIDTH:0]   o_FILL_LEVEL,
  output logic                    o_OVERFLOW,
  output logic                    o_UNDERFLOW
);

  localparam int lp_FW = p_ADDR_WIDTH + 1;
  localparam logic [lp_FW-1:0] lp_DEPTH = {1'b1, {p_ADDR_WIDTH{1'b0}}};
  localparam logic [lp_FW-1:0] lp_AF_T  = lp_FW'(p_ALMOST_FULL_THRESHOLD);
  localparam logic [lp_FW-1:0] lp_AE_T  = lp_FW'(p_ALMOST_EMPTY_THRESHOLD);
  localparam logic [lp_FW-1:0] lp_ZERO  = {lp_FW{1'b0}};

  logic [p_DATA_WIDTH-1:0] r_mem [lp_DEPTH];
  logic [p_ADDR_WIDTH-1:0] r_wptr;
  logic [p_ADDR_WIDTH-1:0] r_rptr;
  logic [lp_FW-1:0]        r_fill;
  logic [p_DATA_WIDTH-1:0] r_output;
  logic                    r_output_valid;
  logic                    r_empty;
  logic                    r_full;
  logic                    r_almost_empty;
  logic                    r_almost_full;
  logic                    r_overflow;
  logic                    r_underflow;

  logic                    w_read_ok;
  logic                    w_write_ok;
  logic [lp_FW-1:0]        w_fill_next;

  // When the FIFO is full, a simultaneous read frees the slot that the write then uses.
  assign w_read_ok  = i_READ_REQUEST & ~r_empty;
  assign w_write_ok = i_WRITE_REQUEST & (~r_full | w_read_ok);

  // Compute the next occupancy from the accepted operations.
  always_comb begin
    w_fill_next = r_fill;
    case ({w_write_ok, w_read_ok})
      2'b10:   w_fill_next = r_fill + lp_FW'(1);
      2'b01:   w_fill_next = r_fill - lp_FW'(1);
      default: w_fill_next = r_fill;
    endcase
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge i_CLK) begin
    if (w_write_ok) begin
      r_mem[r_wptr] <= i_INPUT;
    end
  end

  // Pointers, fill level, read data and all status flags.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_wptr         <= {p_ADDR_WIDTH{1'b0}};
      r_rptr         <= {p_ADDR_WIDTH{1'b0}};
      r_fill         <= lp_ZERO;
      r_output       <= {p_DATA_WIDTH{1'b0}};
      r_output_valid <= 1'b0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= (lp_ZERO <= lp_AE_T);
      r_almost_full  <= (lp_ZERO >= lp_AF_T);
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_write_ok) begin
        r_wptr <= r_wptr + p_ADDR_WIDTH'(1);
      end
      if (w_read_ok) begin
        r_rptr         <= r_rptr + p_ADDR_WIDTH'(1);
        r_output       <= r_mem[r_rptr];
        r_output_valid <= 1'b1;
      end else begin
        r_output_valid <= 1'b0;
      end
      r_fill         <= w_fill_next;
      r_empty        <= (w_fill_next == lp_ZERO);
      r_full         <= (w_fill_next == lp_DEPTH);
      r_almost_empty <= (w_fill_next <= lp_AE_T);
      r_almost_full  <= (w_fill_next >= lp_AF_T);
      if (i_WRITE_REQUEST && !w_write_ok) begin
        r_overflow <= 1'b1;
      end
      if (i_READ_REQUEST && !w_read_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_OUTPUT       = r_output;
  assign o_OUTPUT_VALID = r_output_valid;
  assign o_FIFO_EMPTY   = r_empty;
  assign o_FIFO_FULL    = r_full;
  assign o_ALMOST_EMPTY = r_almost_empty;
  assign o_ALMOST_FULL  = r_almost_full;
  assign o_FILL_LEVEL   = r_fill;
  assign o_OVERFLOW     = r_overflow;
  assign o_UNDERFLOW    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged. A queue-based reference model is compared on every
// falling edge, and literal expectations pin the key scenarios.
module tb_sync_fifo_flagged;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dvalid;
  logic       empty;
  logic       full;
  logic       aempty;
  logic       afull;
  logic [3:0] fill;
  logic       ovf;
  logic       unf;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_ovf;
  logic       m_unf;

  sync_fifo_flagged dut (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_WRITE_REQUEST(wr), .i_READ_REQUEST(rd),
    .i_INPUT(din), .o_OUTPUT(dout), .o_OUTPUT_VALID(dvalid), .o_FIFO_EMPTY(empty),
    .o_FIFO_FULL(full), .o_ALMOST_EMPTY(aempty), .o_ALMOST_FULL(afull),
    .o_FILL_LEVEL(fill), .o_OVERFLOW(ovf), .o_UNDERFLOW(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_out   = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock of stimulus. The model advances at the edge using the state it held before the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit rd_ok;
    bit wr_ok;
    wr  = w;
    rd  = r;
    din = d;
    rd_ok = r && (m_q.size() > 0);
    wr_ok = w && ((m_q.size() < 8) || rd_ok);
    @(posedge clk);
    if (rd_ok) m_out = m_q.pop_front();
    m_valid = rd_ok;
    if (wr_ok) m_q.push_back(d);
    if (w && !wr_ok) m_ovf = 1'b1;
    if (r && !rd_ok) m_unf = 1'b1;
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("model_fill",   {28'd0, fill},   m_q.size());
    check("model_empty",  {31'd0, empty},  {31'd0, m_q.size() == 0});
    check("model_full",   {31'd0, full},   {31'd0, m_q.size() == 8});
    check("model_aempty", {31'd0, aempty}, {31'd0, m_q.size() <= 2});
    check("model_afull",  {31'd0, afull},  {31'd0, m_q.size() >= 6});
    check("model_out",    {24'd0, dout},   {24'd0, m_out});
    check("model_valid",  {31'd0, dvalid}, {31'd0, m_valid});
    check("model_ovf",    {31'd0, ovf},    {31'd0, m_ovf});
    check("model_unf",    {31'd0, unf},    {31'd0, m_unf});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    wr = 1'b0; rd = 1'b0; din = 8'h00; rst_n = 1'b1;
    model_clear();
    #2;
    do_reset();
    check("rst_fill",   {28'd0, fill},   32'd0);
    check("rst_empty",  {31'd0, empty},  32'd1);
    check("rst_aempty", {31'd0, aempty}, 32'd1);
    check("rst_afull",  {31'd0, afull},  32'd0);
    check("rst_out",    {24'd0, dout},   32'd0);

    // Fill to full with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check("wr_fill",  {28'd0, fill},  32'(i));
      check("wr_afull", {31'd0, afull}, (i >= 6) ? 32'd1 : 32'd0);
      check("wr_full",  {31'd0, full},  (i == 8) ? 32'd1 : 32'd0);
      check("wr_empty", {31'd0, empty}, 32'd0);
    end
    check("no_ovf", {31'd0, ovf}, 32'd0);

    // A write to a full FIFO is dropped.
    step(1'b1, 1'b0, 8'hAA);
    check("ovf_set",  {31'd0, ovf},  32'd1);
    check("ovf_fill", {28'd0, fill}, 32'd8);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("rd_data",   {24'd0, dout},   32'(i + 1));
      check("rd_valid",  {31'd0, dvalid}, 32'd1);
      check("rd_aempty", {31'd0, aempty}, (7 - i <= 2) ? 32'd1 : 32'd0);
      check("rd_empty",  {31'd0, empty},  (i == 7) ? 32'd1 : 32'd0);
    end
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // A read from an empty FIFO is rejected.
    step(1'b0, 1'b1, 8'h00);
    check("unf_set",   {31'd0, unf},    32'd1);
    check("unf_valid", {31'd0, dvalid}, 32'd0);
    check("unf_out",   {24'd0, dout},   32'h08);

    // Read and write together while full.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b1, 8'h99);
    check("fullrw_out",  {24'd0, dout},  32'h10);
    check("fullrw_fill", {28'd0, fill},  32'd8);
    check("fullrw_full", {31'd0, full},  32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("fullrw_drain", {24'd0, dout}, (i == 7) ? 32'h99 : 32'(8'h11 + i));
    end

    // Read and write together while empty: the write is accepted and the read underflows.
    do_reset();
    step(1'b1, 1'b1, 8'h55);
    check("emptyrw_fill",  {28'd0, fill},   32'd1);
    check("emptyrw_unf",   {31'd0, unf},    32'd1);
    check("emptyrw_valid", {31'd0, dvalid}, 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("emptyrw_data", {24'd0, dout}, 32'h55);

    // Prefill 3 words, then stream 20 words through with a read and write every cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h23 + i));
      check("stream_data", {24'd0, dout}, 32'(8'h20 + i));
      check("stream_fill", {28'd0, fill}, 32'd3);
    end

    // Assert reset asynchronously between clock edges in the middle of the stream.
    wr = 1'b1; rd = 1'b1; din = 8'hEE;
    #2;
    rst_n = 1'b0;
    model_clear();
    wr = 1'b0; rd = 1'b0;
    #1;
    check("arst_fill",  {28'd0, fill},   32'd0);
    check("arst_empty", {31'd0, empty},  32'd1);
    check("arst_valid", {31'd0, dvalid}, 32'd0);
    check("arst_out",   {24'd0, dout},   32'd0);
    check("arst_ovf",   {31'd0, ovf},    32'd0);
    check("arst_unf",   {31'd0, unf},    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_data",  {24'd0, dout},   32'h77);
    check("post_rst_valid", {31'd0, dvalid}, 32'd1);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flagged.md
# sync_fifo_flagged

Parametrised single-clock FIFO with asynchronous active-low reset, full usable depth of 2**p_ADDR_WIDTH, registered fill level, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Successor to the basic synchronous FIFO: guards against illegal requests in hardware and exposes occupancy to upstream flow control and downstream consumers. Sits between any two same-clock producer/consumer blocks in the datapath.

## Interface
- p_DATA_WIDTH, 8, word width in bits
- p_ADDR_WIDTH, 3, pointer width; depth D = 2**p_ADDR_WIDTH (all D entries usable)
- p_ALMOST_FULL_THRESHOLD, 6, o_ALMOST_FULL asserts when fill ≥ this value; legal range 1..D
- p_ALMOST_EMPTY_THRESHOLD, 2, o_ALMOST_EMPTY asserts when fill ≤ this value; legal range 0..D-1
- i_CLK  input  1  clock; all state changes on rising edge
- i_RESET_N  input  1  asynchronous, active-low reset
- i_WRITE_REQUEST  input  1  push i_INPUT this cycle
- i_READ_REQUEST  input  1  pop head entry this cycle
- i_INPUT  input  p_DATA_WIDTH  write data
- o_OUTPUT  output  p_DATA_WIDTH  read data, registered
- o_OUTPUT_VALID  output  1  one-cycle pulse: o_OUTPUT holds a newly popped word
- o_FIFO_EMPTY  output  1  fill == 0
- o_FIFO_FULL  output  1  fill == D
- o_ALMOST_EMPTY  output  1  fill ≤ p_ALMOST_EMPTY_THRESHOLD
- o_ALMOST_FULL  output  1  fill ≥ p_ALMOST_FULL_THRESHOLD
- o_FILL_LEVEL  output  p_ADDR_WIDTH+1  current entry count, 0..D
- o_OVERFLOW  output  1  sticky: a write was dropped
- o_UNDERFLOW  output  1  sticky: a read was rejected

## Operation
- Storage: D × p_DATA_WIDTH array, not reset. Write and read pointers are p_ADDR_WIDTH bits, wrap modulo D naturally (D-1 → 0).
- Fill counter p_ADDR_WIDTH+1 bits; never wraps; held in 0..D by acceptance rules.
- Acceptance (evaluated against pre-edge state):
  - write_ok = i_WRITE_REQUEST & (!full | read_ok)
  - read_ok = i_READ_REQUEST & !empty
  - Simultaneous read+write when empty: write accepted, read rejected (underflow). When full: both accepted; read returns the old head, write stores into the freed slot; fill unchanged.
- Accepted write: mem[wptr] ← i_INPUT, wptr += 1. Accepted read: o_OUTPUT ← mem[rptr], rptr += 1, o_OUTPUT_VALID ← 1; otherwise o_OUTPUT holds, o_OUTPUT_VALID ← 0.
- Fill next = fill + write_ok − read_ok.
- All status flags are registered and computed from fill-next, so on every cycle they are consistent with o_FILL_LEVEL.
- Rejected write (i_WRITE_REQUEST & !write_ok) sets o_OVERFLOW; rejected read sets o_UNDERFLOW. Both stay set until reset; rejected operations change no other state.
- Reset (i_RESET_N low, asynchronous assert, synchronous-to-clock release): pointers 0, fill 0, o_OUTPUT 0, o_OUTPUT_VALID 0, o_FIFO_EMPTY 1, o_FIFO_FULL 0, o_ALMOST_EMPTY 1, o_ALMOST_FULL 0 (unless threshold 0 rules apply per formula), o_FILL_LEVEL 0, o_OVERFLOW 0, o_UNDERFLOW 0. Reset mid-operation discards all contents; memory contents afterwards are don't-care and never visible.

## Timing
- Write-to-flag latency: 1 edge (flags/fill reflect a write at the edge that accepts it).
- Write-to-read: a word written at edge N may be popped by a request at edge N+1; its data appears on o_OUTPUT after edge N+1 with o_OUTPUT_VALID high for that cycle.
- Read latency: 1 cycle, request to data.
- Back-to-back reads/writes sustain one word per clock each; no bubble at pointer wrap.
- No combinational path from inputs to outputs.

## Test plan
- Reset then 8 writes 0x01..0x08 (defaults): fill 1..8, o_ALMOST_FULL rises with fill 6, o_FIFO_FULL with fill 8, o_FIFO_EMPTY drops after first write; no error flags.
- From full, 8 reads: o_OUTPUT 0x01..0x08 each with o_OUTPUT_VALID pulse, o_ALMOST_EMPTY rises at fill 2, o_FIFO_EMPTY at fill 0.
- Full + write 0xAA alone: o_OVERFLOW set and sticky, fill stays 8, subsequent reads return 0x01..0x08 (0xAA absent). Empty + read: o_UNDERFLOW set, o_OUTPUT_VALID stays 0, o_OUTPUT unchanged.
- Simultaneous read+write at fill 8: output returns head, fill stays 8, no overflow; at fill 0 with write 0x55: fill 1, o_UNDERFLOW set, next read returns 0x55.
- Stream 20 words with continuous read+write after 3-word prefill: pointers wrap twice, output order exactly matches input order, fill constant at 3.
- Assert i_RESET_N low mid-stream between edges: all outputs reach reset values immediately; after release, a write of 0x77 then read returns 0x77.
